// File: rtl/phase_frame_loader.sv
// Framed byte-stream loader for shared-divide phased clock channels.
// Shadows offsets/divide, then applies atomically under a channel reset pulse.
module phase_frame_loader #(
  parameter int N_CH           = 8,
  parameter int OFFSET_WIDTH   = 11,
  parameter int DIVIDE_DEFAULT = 624,
  parameter int LOAD_CYCLES    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic                         rx_ready,
  output logic [N_CH*OFFSET_WIDTH-1:0] offsets,
  output logic [OFFSET_WIDTH-2:0]      divide,
  output logic                         ch_rst_n,
  output logic                         ch_oe,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         frame_err
);
  localparam int OW = OFFSET_WIDTH;
  localparam int HW = OW - 8;
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  localparam logic [7:0] HDR_OFS = 8'hA5;
  localparam logic [7:0] HDR_DIV = 8'hD1;
  localparam logic [7:0] OE_OFF  = 8'hC0;
  localparam logic [7:0] OE_ON   = 8'hC1;
  localparam logic [7:0] COMMIT_B = 8'h5A;

  localparam logic [OW-2:0] DIV_RST = (OW-1)'(DIVIDE_DEFAULT);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_CH - 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LOAD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, OFS_HI, OFS_LO, DIV_HI, DIV_LO, COMMIT, APPLY
  } state_t;

  state_t              r_state;
  logic [N_CH*OW-1:0]  r_ofs;
  logic [N_CH*OW-1:0]  r_sh_ofs;
  logic [OW-2:0]       r_div;
  logic [OW-2:0]       r_sh_div;
  logic [HW-1:0]       r_hi;
  logic [IW-1:0]       r_idx;
  logic [CW-1:0]       r_cnt;
  logic                r_ch_rst_n;
  logic                r_oe;
  logic                r_done;
  logic                r_err;

  logic                w_fire;
  logic                w_err;
  logic [OW-1:0]       w_ofs_val;
  logic [OW-2:0]       w_div_val;

  assign rx_ready   = (r_state != APPLY);
  assign w_fire     = rx_valid && rx_ready;
  assign w_ofs_val  = {r_hi, rx_data};
  assign w_div_val  = {r_hi[HW-2:0], rx_data};

  assign offsets    = r_ofs;
  assign divide     = r_div;
  assign ch_rst_n   = r_ch_rst_n;
  assign ch_oe      = r_oe;
  assign busy       = (r_state != IDLE);
  assign frame_done = r_done;
  assign frame_err  = r_err;

  always_comb begin
    w_err = 1'b0;
    if (w_fire) begin
      unique case (r_state)
        OFS_HI:  w_err = (rx_data >> HW) != 8'd0;
        DIV_HI:  w_err = (rx_data >> (HW - 1)) != 8'd0;
        COMMIT:  w_err = (rx_data != COMMIT_B);
        default: w_err = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_ofs      <= '0;
      r_sh_ofs   <= '0;
      r_div      <= DIV_RST;
      r_sh_div   <= DIV_RST;
      r_hi       <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_ch_rst_n <= 1'b0;
      r_oe       <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_ch_rst_n <= 1'b1;
      if (w_err) begin
        // Drop the staged frame so the next one starts from live values.
        r_err    <= 1'b1;
        r_sh_ofs <= r_ofs;
        r_sh_div <= r_div;
        r_state  <= IDLE;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (w_fire) begin
              unique case (1'b1)
                rx_data == HDR_OFS: begin
                  r_idx   <= '0;
                  r_state <= OFS_HI;
                end
                rx_data == HDR_DIV: r_state <= DIV_HI;
                rx_data == OE_OFF:  r_oe <= 1'b0;
                rx_data == OE_ON:   r_oe <= 1'b1;
                default: ;
              endcase
            end
          end
          OFS_HI: begin
            if (w_fire) begin
              r_hi    <= rx_data[HW-1:0];
              r_state <= OFS_LO;
            end
          end
          OFS_LO: begin
            if (w_fire) begin
              r_sh_ofs[int'(r_idx)*OW +: OW] <= w_ofs_val;
              if (r_idx == IDX_LAST) begin
                r_state <= COMMIT;
              end else begin
                r_idx   <= r_idx + 1'b1;
                r_state <= OFS_HI;
              end
            end
          end
          DIV_HI: begin
            if (w_fire) begin
              r_hi    <= rx_data[HW-1:0];
              r_state <= DIV_LO;
            end
          end
          DIV_LO: begin
            if (w_fire) begin
              r_sh_div <= w_div_val;
              r_state  <= COMMIT;
            end
          end
          COMMIT: begin
            if (w_fire) begin
              r_ofs      <= r_sh_ofs;
              r_div      <= r_sh_div;
              r_ch_rst_n <= 1'b0;
              r_cnt      <= CNT_LOAD;
              r_state    <= APPLY;
            end
          end
          APPLY: begin
            if (r_cnt == '0) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_ch_rst_n <= 1'b0;
              r_cnt      <= r_cnt - 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phase_frame_loader.sv
// Directed bench for phase_frame_loader: frame table plus
// hand-written OE, back-pressure and mid-frame reset sequences.
module tb_phase_frame_loader;
  localparam int N  = 8;
  localparam int OW = 11;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic            rx_valid = 1'b0;
  logic            rx_ready;
  logic [N*OW-1:0] offsets;
  logic [OW-2:0]   divide;
  logic            ch_rst_n;
  logic            ch_oe;
  logic            busy;
  logic            frame_done;
  logic            frame_err;

  phase_frame_loader #(
    .N_CH(N), .OFFSET_WIDTH(OW),
    .DIVIDE_DEFAULT(624), .LOAD_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .offsets(offsets), .divide(divide),
    .ch_rst_n(ch_rst_n), .ch_oe(ch_oe), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_low = 0, n_done = 0, n_err = 0, n_oelow = 0;

  always @(negedge clk) begin
    if (!ch_rst_n) n_low++;
    if (frame_done) n_done++;
    if (frame_err) n_err++;
    if (!ch_oe) n_oelow++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    string           name;
    logic [7:0]      hdr;
    logic [7:0][15:0] v;
    logic [7:0]      cmt;
    int              nb;
    bit              ok;
    int              e0, e3, e7, ediv;
  } vec_t;

  vec_t tbl[8];

  function automatic vec_t mk(string nm, logic [7:0] h, logic [7:0] c,
                              int nb, bit ok, int e0, int e3, int e7,
                              int ed);
    vec_t r;
    r.name = nm; r.hdr = h; r.v = '0; r.cmt = c; r.nb = nb;
    r.ok = ok; r.e0 = e0; r.e3 = e3; r.e7 = e7; r.ediv = ed;
    return r;
  endfunction

  function automatic int ch(int i);
    return int'(offsets[i*OW +: OW]);
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, output int stalls);
    logic r;
    bit   got;
    stalls = 0;
    got = 0;
    rx_data = b;
    rx_valid = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      r = rx_ready;
      @(posedge clk); #1;
      if (r) got = 1; else stalls++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %h not accepted in 20 cycles", b);
    end
  endtask

  task automatic idle_wait(int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] q[$];
    int st, nbytes;
    int s_low, s_done, s_err, s_oe;

    tbl[0] = mk("ofs_ramp",      8'hA5, 8'h5A, 0, 1, 0,    30,   70,   624);
    tbl[1] = mk("ofs_badhi",     8'hA5, 8'h5A, 8, 0, 0,    30,   70,   624);
    tbl[2] = mk("div_499",       8'hD1, 8'h5A, 0, 1, 0,    30,   70,   499);
    tbl[3] = mk("ofs_badcommit", 8'hA5, 8'h5B, 0, 0, 0,    30,   70,   499);
    tbl[4] = mk("div_max",       8'hD1, 8'h5A, 0, 1, 0,    30,   70,   1023);
    tbl[5] = mk("div_badhi",     8'hD1, 8'h5A, 2, 0, 0,    30,   70,   1023);
    tbl[6] = mk("ofs_edges",     8'hA5, 8'h5A, 0, 1, 2047, 1023, 1792, 1023);
    tbl[7] = mk("div_badcommit", 8'hD1, 8'h00, 0, 0, 2047, 1023, 1792, 1023);
    for (int i = 0; i < 8; i++) tbl[0].v[i] = 16'(10 * i);
    for (int i = 0; i < 3; i++) tbl[1].v[i] = 16'(100 + i);
    tbl[1].v[3] = 16'h0800;
    tbl[2].v[0] = 16'h01F3;
    for (int i = 0; i < 8; i++) tbl[3].v[i] = 16'h0123;
    tbl[4].v[0] = 16'h03FF;
    tbl[5].v[0] = 16'h0400;
    tbl[6].v = {16'h0700, 16'h02AA, 16'h0555, 16'h0001,
                16'h03FF, 16'h0000, 16'h0400, 16'h07FF};
    tbl[7].v[0] = 16'h0064;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ofs_nonzero", int'(|offsets), 0);
    chk("rst_divide", int'(divide), 624);
    chk("rst_ch_oe", int'(ch_oe), 0);
    chk("rst_ch_rst_n", int'(ch_rst_n), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rx_ready", int'(rx_ready), 1);
    chk("rst_pulses", int'(frame_done) + int'(frame_err), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("release_ch_rst_n", int'(ch_rst_n), 1);
    idle_wait(2);
    chk("idle_divide", int'(divide), 624);
    chk("idle_busy", int'(busy), 0);

    for (int r = 0; r < 8; r++) begin
      q.delete();
      q.push_back(tbl[r].hdr);
      if (tbl[r].hdr == 8'hA5) begin
        for (int i = 0; i < N; i++) begin
          q.push_back(tbl[r].v[i][15:8]);
          q.push_back(tbl[r].v[i][7:0]);
        end
      end else begin
        q.push_back(tbl[r].v[0][15:8]);
        q.push_back(tbl[r].v[0][7:0]);
      end
      q.push_back(tbl[r].cmt);
      nbytes = (tbl[r].nb != 0) ? tbl[r].nb : q.size();
      s_low = n_low; s_done = n_done; s_err = n_err;
      for (int k = 0; k < nbytes; k++) send(q[k], st);
      idle_wait(6);
      chk({tbl[r].name, "_err"},  n_err - s_err,   tbl[r].ok ? 0 : 1);
      chk({tbl[r].name, "_done"}, n_done - s_done, tbl[r].ok ? 1 : 0);
      chk({tbl[r].name, "_low"},  n_low - s_low,   tbl[r].ok ? 2 : 0);
      chk({tbl[r].name, "_ch0"},  ch(0), tbl[r].e0);
      chk({tbl[r].name, "_ch3"},  ch(3), tbl[r].e3);
      chk({tbl[r].name, "_ch7"},  ch(7), tbl[r].e7);
      chk({tbl[r].name, "_div"},  int'(divide), tbl[r].ediv);
    end

    // OE on, then frames streamed with rx_valid held across APPLY
    send(8'hC1, st);
    chk("oe_on", int'(ch_oe), 1);
    s_low = n_low; s_done = n_done; s_oe = n_oelow;
    send(8'hA5, st);
    for (int i = 0; i < N; i++) begin
      send(8'h01, st);
      send(8'(i), st);
    end
    send(8'h5A, st);
    send(8'hD1, st);
    chk("hold_stalls", st, 2);
    send(8'h00, st);
    send(8'h32, st);
    send(8'h5A, st);
    idle_wait(6);
    chk("hold_oe_low_cycles", n_oelow - s_oe, 0);
    chk("hold_done", n_done - s_done, 2);
    chk("hold_low", n_low - s_low, 4);
    chk("hold_ch3", ch(3), 259);
    chk("hold_ch7", ch(7), 263);
    chk("hold_div", int'(divide), 50);

    // Asynchronous reset mid-frame
    send(8'hA5, st);
    send(8'h07, st);
    send(8'h77, st);
    send(8'h07, st);
    send(8'h77, st);
    rx_valid = 1'b0;
    rst = 1'b0;
    #2;
    chk("abort_ofs_nonzero", int'(|offsets), 0);
    chk("abort_divide", int'(divide), 624);
    chk("abort_ch_oe", int'(ch_oe), 0);
    chk("abort_ch_rst_n", int'(ch_rst_n), 0);
    chk("abort_busy", int'(busy), 0);
    #3;
    rst = 1'b1;
    @(posedge clk); #1;
    send(8'hD1, st);
    send(8'h00, st);
    send(8'h64, st);
    send(8'h5A, st);
    idle_wait(6);
    chk("post_abort_div", int'(divide), 100);
    chk("post_abort_ch0", ch(0), 0);
    chk("post_abort_ch7", ch(7), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
